// File: rtl/led_bcm_sequencer_if.sv
// Sequencer-to-panel signal bundle for led_bcm_sequencer.
// Port `dim` exists only when LED_BCM_DIM_EN is defined.
interface led_bcm_sequencer_if #(
    parameter int COLS    = 64,
    parameter int ROWS    = 32,
    parameter int PLANES  = 8,
    parameter int FRAME_W = 13
);
    localparam int XW = $clog2(COLS);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;

    logic               run;
`ifdef LED_BCM_DIM_EN
    logic [2:0]         dim;
`endif
    logic [XW-1:0]      x;
    logic [RW-1:0]      row;
    logic [PW-1:0]      plane;
    logic               sclk_ena;
    logic [RW-1:0]      led_addr;
    logic               led_blank;
    logic               led_latch;
    logic [FRAME_W-1:0] frame;
    logic               frame_strobe;

    modport master (
        input  run,
`ifdef LED_BCM_DIM_EN
        input  dim,
`endif
        output x, row, plane, sclk_ena,
        output led_addr, led_blank, led_latch,
        output frame, frame_strobe
    );

    modport slave (
        output run,
`ifdef LED_BCM_DIM_EN
        output dim,
`endif
        input  x, row, plane, sclk_ena,
        input  led_addr, led_blank, led_latch,
        input  frame, frame_strobe
    );
endinterface

// File: rtl/led_bcm_sequencer.sv
// BCM scan scheduler for a HUB75 panel: shift, blank, latch, show.
// Optional LED_BCM_DIM_EN adds a per-slot dimming cut-off.
module led_bcm_sequencer #(
    parameter int COLS       = 64,
    parameter int ROWS       = 32,
    parameter int PLANES     = 8,
    parameter int BASE_TICKS = 1,
    parameter int FRAME_W    = 13
) (
    input  logic                pll_clk,
    input  logic                reset_n,
    led_bcm_sequencer_if.master bus
);
    localparam int XW   = $clog2(COLS);
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PW   = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int DMAX = BASE_TICKS << (PLANES - 1);
    localparam int DT_W = $clog2(DMAX + 1);

    localparam int B_IDLE    = 0;
    localparam int B_SHIFT   = 1;
    localparam int B_WAIT    = 2;
    localparam int B_BLANK   = 3;
    localparam int B_LATCH   = 4;
    localparam int B_UNLATCH = 5;
    localparam int B_UNBLANK = 6;
    localparam int B_DRAIN   = 7;

    typedef enum logic [7:0] {
        S_IDLE    = 8'b0000_0001,
        S_SHIFT   = 8'b0000_0010,
        S_WAIT    = 8'b0000_0100,
        S_BLANK   = 8'b0000_1000,
        S_LATCH   = 8'b0001_0000,
        S_UNLATCH = 8'b0010_0000,
        S_UNBLANK = 8'b0100_0000,
        S_DRAIN   = 8'b1000_0000
    } state_t;

    state_t             r_state;
    state_t             w_state;
    logic [XW-1:0]      r_x;
    logic [XW-1:0]      w_x;
    logic [RW-1:0]      r_row;
    logic [RW-1:0]      w_row;
    logic [PW-1:0]      r_plane;
    logic [PW-1:0]      w_plane;
    logic               r_sclk;
    logic               r_blank;
    logic               w_blank;
    logic               r_latch;
    logic               w_latch;
    logic [RW-1:0]      r_addr;
    logic [RW-1:0]      w_addr;
    logic [FRAME_W-1:0] r_frame;
    logic [FRAME_W-1:0] w_frame;
    logic               r_fstb;
    logic               w_fstb;
    logic [DT_W-1:0]    r_dt;
    logic [DT_W-1:0]    w_dt;
    logic [DT_W-1:0]    w_d;
    logic               w_pwrap;
    logic               w_rwrap;

    assign w_d     = DT_W'(BASE_TICKS) << r_plane;
    assign w_pwrap = (r_plane == PW'(PLANES - 1));
    assign w_rwrap = (r_row == RW'(ROWS - 1));

    always_comb begin
        w_state = r_state;
        w_x     = r_x;
        w_row   = r_row;
        w_plane = r_plane;
        w_blank = r_blank;
        w_latch = r_latch;
        w_addr  = r_addr;
        w_frame = r_frame;
        w_fstb  = 1'b0;
        w_dt    = (r_dt != '0) ? r_dt - DT_W'(1) : r_dt;
        unique case (1'b1)
            r_state[B_IDLE]: begin
                w_blank = 1'b1;
                if (bus.run) w_state = S_SHIFT;
            end
            r_state[B_SHIFT]: begin
                // x wraps back to 0 on the last column
                w_x = r_x + XW'(1);
                if (r_x == XW'(COLS - 1)) w_state = S_WAIT;
            end
            r_state[B_WAIT]: begin
                if (r_dt == '0) w_state = S_BLANK;
            end
            r_state[B_BLANK]: begin
                w_blank = 1'b1;
                w_addr  = r_row;
                w_state = S_LATCH;
            end
            r_state[B_LATCH]: begin
                w_latch = 1'b1;
                w_state = S_UNLATCH;
            end
            r_state[B_UNLATCH]: begin
                w_latch = 1'b0;
                w_state = S_UNBLANK;
            end
            r_state[B_UNBLANK]: begin
                w_blank = 1'b0;
                w_dt    = w_d;
                if (w_pwrap) begin
                    w_plane = '0;
                    if (w_rwrap) begin
                        w_row   = '0;
                        w_frame = r_frame + FRAME_W'(1);
                        w_fstb  = 1'b1;
                    end else begin
                        w_row = r_row + RW'(1);
                    end
                end else begin
                    w_plane = r_plane + PW'(1);
                end
                w_state = bus.run ? S_SHIFT : S_DRAIN;
            end
            r_state[B_DRAIN]: begin
                if (r_dt == '0) begin
                    w_blank = 1'b1;
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge pll_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_row   <= '0;
            r_plane <= '0;
            r_sclk  <= 1'b0;
            r_blank <= 1'b1;
            r_latch <= 1'b0;
            r_addr  <= '0;
            r_frame <= '0;
            r_fstb  <= 1'b0;
            r_dt    <= '0;
        end else begin
            r_state <= w_state;
            r_x     <= w_x;
            r_row   <= w_row;
            r_plane <= w_plane;
            r_sclk  <= r_state[B_SHIFT];
            r_blank <= w_blank;
            r_latch <= w_latch;
            r_addr  <= w_addr;
            r_frame <= w_frame;
            r_fstb  <= w_fstb;
            r_dt    <= w_dt;
        end
    end

`ifdef LED_BCM_DIM_EN
    logic [DT_W-1:0] r_dimc;
    logic [DT_W-1:0] w_dimc;
    logic            r_dim_off;
    logic            w_dim_off;

    // Once the dim counter runs out the panel stays dark until the next show.
    always_comb begin
        w_dimc    = (r_dimc != '0) ? r_dimc - DT_W'(1) : r_dimc;
        w_dim_off = r_dim_off | (r_dimc == '0);
        if (r_state[B_UNBLANK]) begin
            w_dimc    = w_d >> bus.dim;
            w_dim_off = 1'b0;
        end
    end

    always_ff @(posedge pll_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dimc    <= '0;
            r_dim_off <= 1'b0;
        end else begin
            r_dimc    <= w_dimc;
            r_dim_off <= w_dim_off;
        end
    end

    assign bus.led_blank = r_blank | r_dim_off;
`else
    assign bus.led_blank = r_blank;
`endif

    assign bus.x            = r_x;
    assign bus.row          = r_row;
    assign bus.plane        = r_plane;
    assign bus.sclk_ena     = r_sclk;
    assign bus.led_addr     = r_addr;
    assign bus.led_latch    = r_latch;
    assign bus.frame        = r_frame;
    assign bus.frame_strobe = r_fstb;
endmodule

// File: tb/tb_led_bcm_sequencer.sv
// Scoreboard bench for led_bcm_sequencer: two small configs,
// BASE_TICKS=8 (A) and BASE_TICKS=1 (B); LED_BCM_DIM_EN aware.
module tb_led_bcm_sequencer;
`ifdef LED_BCM_DIM_EN
    localparam bit DIM = 1'b1;
`else
    localparam bit DIM = 1'b0;
`endif
    localparam int DIM_A = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    led_bcm_sequencer_if #(
        .COLS(4), .ROWS(2), .PLANES(2), .FRAME_W(13)
    ) ia ();
    led_bcm_sequencer_if #(
        .COLS(4), .ROWS(2), .PLANES(2), .FRAME_W(13)
    ) ib ();

    led_bcm_sequencer #(
        .COLS(4), .ROWS(2), .PLANES(2),
        .BASE_TICKS(8), .FRAME_W(13)
    ) dut_a (
        .pll_clk(clk),
        .reset_n(rst_n),
        .bus(ia)
    );

    led_bcm_sequencer #(
        .COLS(4), .ROWS(2), .PLANES(2),
        .BASE_TICKS(1), .FRAME_W(13)
    ) dut_b (
        .pll_clk(clk),
        .reset_n(rst_n),
        .bus(ib)
    );

    int n_checks = 0;
    int n_errors = 0;

    int q_first[$];
    int q_addr[$];
    int q_per[$];
    int q_on[$];
    int q_rp[$];
    int q_frame[$];
    int q_bon[$];
    int q_bper[$];

    bit mon_en = 1'b0;
    int n_latch = 0;

    task automatic check(input string nm, input int act,
                         input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d",
                     nm, act, exp);
        end
    endtask

    task automatic miss(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event seen with nothing expected", nm);
    endtask

    function automatic int on_exp(input int d, input int cols,
                                  input int dm, input bit drain);
        int full;
        full = drain ? d + 1 : ((d > cols) ? d : cols) + 2;
        if (DIM && ((d >> dm) + 1 < full)) full = (d >> dm) + 1;
        return full;
    endfunction

    task automatic push_slot(input int r, input int p,
                             input bit dr);
        q_rp.push_back(r * 2 + p);
        q_addr.push_back(r);
        q_on.push_back(on_exp(8 << p, 4, DIM_A, dr));
    endtask

    // Monitor for config A
    initial begin
        int cyc, run_cyc, last_l, zrun, srun, since;
        bit armed, have_l;
        logic p_run, p_blank, p_sclk;
        logic [1:0] p_x;
        logic p_row, p_plane, p_addr;
        cyc = 0; run_cyc = 0; last_l = 0; zrun = 0;
        srun = 0; since = 0; armed = 0; have_l = 0;
        p_run = 0; p_blank = 1; p_sclk = 0; p_x = 0;
        p_row = 0; p_plane = 0; p_addr = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (ia.run && !p_run) begin
                    run_cyc = cyc;
                    armed = 1;
                end
                if (ia.led_latch) begin
                    n_latch++;
                    since++;
                    if (armed) begin
                        armed = 0;
                        if (q_first.size() > 0)
                            check("first_latch", cyc - run_cyc,
                                  q_first.pop_front());
                        else miss("first_latch");
                    end
                    if (q_addr.size() > 0)
                        check("latch_addr", int'(ia.led_addr),
                              q_addr.pop_front());
                    else miss("latch_addr");
                    if (have_l) begin
                        if (q_per.size() == 0) miss("slot_period");
                        else begin
                            int e;
                            e = q_per.pop_front();
                            if (e >= 0)
                                check("slot_period", cyc - last_l, e);
                        end
                    end
                    have_l = 1;
                    last_l = cyc;
                end
                if (!ia.led_blank) zrun++;
                else if (zrun > 0) begin
                    if (q_on.size() > 0)
                        check("on_time", zrun, q_on.pop_front());
                    else miss("on_time");
                    zrun = 0;
                end
                if (ia.sclk_ena) srun++;
                if (ia.sclk_ena && !p_sclk) begin
                    check("sclk_lag_x", int'(p_x), 0);
                    if (q_rp.size() > 0)
                        check("row_plane",
                              int'(p_row) * 2 + int'(p_plane),
                              q_rp.pop_front());
                    else miss("row_plane");
                end
                if (!ia.sclk_ena && p_sclk) begin
                    check("sclk_len", srun, 4);
                    srun = 0;
                end
                if (ia.led_addr != p_addr)
                    check("addr_chg_blank", int'(ia.led_blank), 1);
                if (ia.frame_strobe) begin
                    if (q_frame.size() > 0)
                        check("frame", int'(ia.frame),
                              q_frame.pop_front());
                    else miss("frame");
                    check("slots_per_frame", since, 4);
                    since = 0;
                end
            end
            p_run = ia.run;
            p_blank = ia.led_blank;
            p_sclk = ia.sclk_ena;
            p_x = ia.x;
            p_row = ia.row;
            p_plane = ia.plane;
            p_addr = ia.led_addr;
        end
    end

    // Monitor for config B
    initial begin
        int cyc, bz, blast;
        bit bhave;
        cyc = 0; bz = 0; blast = 0; bhave = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!ib.led_blank) bz++;
            else if (bz > 0) begin
                if (q_bon.size() > 0)
                    check("b_on_time", bz, q_bon.pop_front());
                bz = 0;
            end
            if (ib.led_latch) begin
                if (bhave && q_bper.size() > 0)
                    check("b_slot_period", cyc - blast,
                          q_bper.pop_front());
                bhave = 1;
                blast = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int qleft;
        rst_n = 1'b0;
        ia.run = 1'b0;
        ib.run = 1'b0;
`ifdef LED_BCM_DIM_EN
        ia.dim = 3'(DIM_A);
        ib.dim = 3'd0;
`endif
        @(negedge clk);
        check("rst_blank", int'(ia.led_blank), 1);
        check("rst_latch", int'(ia.led_latch), 0);
        check("rst_frame", int'(ia.frame), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_blank", int'(ia.led_blank), 1);
        check("idle_x", int'(ia.x), 0);
        check("idle_sclk", int'(ia.sclk_ena), 0);
        check("idle_rowplane", int'(ia.row) + int'(ia.plane), 0);
        check("idle_strobe", int'(ia.frame_strobe), 0);

        q_first.push_back(8);
        q_first.push_back(8);
        for (int s = 0; s < 10; s++)
            push_slot((s >> 1) & 1, s & 1, 1'b0);
        push_slot(1, 0, 1'b1);
        push_slot(1, 1, 1'b1);
        for (int s = 0; s < 10; s++)
            q_per.push_back((s & 1) ? 21 : 13);
        q_per.push_back(-1);
        q_frame.push_back(1);
        q_frame.push_back(2);
        q_frame.push_back(3);
        for (int s = 0; s < 4; s++)
            q_bon.push_back(on_exp(1 << (s & 1), 4, 0, 1'b0));
        for (int s = 0; s < 3; s++) q_bper.push_back(9);

        mon_en = 1'b1;
        @(posedge clk);
        #2;
        ia.run = 1'b1;
        ib.run = 1'b1;

        // Let ten slots latch, then drop run inside the next SHIFT.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (n_latch >= 10) break;
        end
        if (n_latch < 10) miss("timeout_ten_latches");
        repeat (2) @(posedge clk);
        #2 ia.run = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (q_on.size() <= 1) break;
        end
        if (q_on.size() > 1) miss("timeout_drain");
        repeat (5) @(negedge clk);
        check("drained_blank", int'(ia.led_blank), 1);
        check("drained_sclk", int'(ia.sclk_ena), 0);
        check("drained_latch", int'(ia.led_latch), 0);

        @(posedge clk);
        #2 ia.run = 1'b1;
        repeat (2) @(posedge clk);
        #2 ia.run = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            qleft = q_first.size() + q_addr.size() + q_per.size()
                  + q_on.size() + q_rp.size() + q_frame.size()
                  + q_bon.size() + q_bper.size();
            if (qleft == 0) break;
        end
        repeat (10) @(posedge clk);
        qleft = q_first.size() + q_addr.size() + q_per.size()
              + q_on.size() + q_rp.size() + q_frame.size()
              + q_bon.size() + q_bper.size();
        check("expected_left", qleft, 0);

        // Async reset while the latch strobe is high.
        mon_en = 1'b0;
        @(posedge clk);
        #2 ia.run = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ia.led_latch) break;
        end
        check("latch_seen", int'(ia.led_latch), 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_latch", int'(ia.led_latch), 0);
        check("async_blank", int'(ia.led_blank), 1);
        check("async_frame", int'(ia.frame), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        ia.run = 1'b0;
        ib.run = 1'b0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
